// File: rtl/data_sram_axi_bridge.sv
// Bridges the core data port's SRAM-like req/addr_ok/data_ok protocol to single-beat AXI4, one transaction at a time.
// Optional build macro BRIDGE_RESP_ERR_EN adds data_err, which flags non-OKAY rresp/bresp.
module data_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // core data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
`ifdef BRIDGE_RESP_ERR_EN
  output logic        data_err,
`endif
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                data_ok_q, data_ok_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
`ifdef BRIDGE_RESP_ERR_EN
  logic                err_q, err_d;
`endif

  logic aw_fire;
  logic w_fire;

  // Channel strobes are pure decodes of the state/flag registers.
  assign data_addr_ok = data_req & (state_q == IDLE);
  assign arvalid      = (state_q == RD_AR);
  assign rready       = (state_q == RD_R);
  assign awvalid      = (state_q == WR_AW_W) & ~aw_done_q;
  assign wvalid       = (state_q == WR_AW_W) & ~w_done_q;
  assign bready       = (state_q == WR_B);
  assign aw_fire      = awvalid & awready;
  assign w_fire       = wvalid & wready;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wdata = wdata_q;
  assign wstrb = wstrb_q;
  assign wlast = 1'b1;

  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;
`ifdef BRIDGE_RESP_ERR_EN
  assign data_err     = err_q;
`endif

  // IDs and rlast carry no information with one single-beat transaction in flight.
  logic unused_resp;
  assign unused_resp = ^{rid, rlast, bid, rresp, bresp};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    data_ok_d = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef BRIDGE_RESP_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (data_req) begin
          addr_d  = data_addr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          wdata_d = data_wdata;
          state_d = data_wr ? WR_AW_W : RD_AR;
        end
      end
      RD_AR: begin
        if (arready) state_d = RD_R;
      end
      RD_R: begin
        if (rvalid) begin
          rdata_d   = rdata;
          data_ok_d = 1'b1;
`ifdef BRIDGE_RESP_ERR_EN
          err_d     = (rresp != 2'b00);
`endif
          state_d   = IDLE;
        end
      end
      WR_AW_W: begin
        // AW and W complete independently; leave once both have handshaken.
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          data_ok_d = 1'b1;
`ifdef BRIDGE_RESP_ERR_EN
          err_d     = (bresp != 2'b00);
`endif
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      data_ok_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef BRIDGE_RESP_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      data_ok_q <= data_ok_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef BRIDGE_RESP_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge; the bench plays the AXI slave, and a scoreboard checks every data_ok completion.
module tb_data_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
`ifdef BRIDGE_RESP_ERR_EN
  logic        data_err;
`endif
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  data_sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
`ifdef BRIDGE_RESP_ERR_EN
    .data_err(data_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = sz;
    data_addr  = addr;
    data_wstrb = be;
    data_wdata = wd;
  endtask

  // Scoreboard: each data_ok pulse consumes the oldest expected completion.
  always @(negedge clk) begin
    if (resetn && data_data_ok) begin
      if (sb.size() == 0) begin
        check("unexpected_data_ok", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_rdata", data_rdata, mon_e.rdata);
`ifdef BRIDGE_RESP_ERR_EN
        check("sb_err", 32'(data_err), 32'(mon_e.err));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    arready = 1'b0; rid = 4'd1; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;
    repeat (3) cyc();
    check("rst_strobes", 32'({arvalid, rready, awvalid, wvalid, bready, data_data_ok}), 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    resetn = 1'b1;
    cyc();
    check("const_ids", 32'({arid, awid}), 32'h11);
    check("const_len_burst", 32'({arlen, awlen, arburst, awburst}), 32'h0005);
    check("const_lock_cache_prot", 32'({arlock, awlock, arcache, awcache, arprot, awprot}), 32'd0);

    // Zero-wait word load
    req(1'b0, 2'd2, 32'h1C000100, 4'hF, 32'd0);
    #1 check("t1_addr_ok", 32'(data_addr_ok), 32'd1);
    sb.push_back('{32'hDEADBEEF, 1'b0});
    cyc(); data_req = 1'b0; arready = 1'b1;
    #1 check("t1_arvalid", 32'(arvalid), 32'd1);
    check("t1_araddr", araddr, 32'h1C000100);
    check("t1_arsize", 32'(arsize), 32'd2);
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
    #1 check("t1_ar_drop_rready", 32'({arvalid, rready, data_data_ok}), 32'b010);
    cyc(); rvalid = 1'b0; rdata = 32'd0;
    #1 check("t1_ok_latency3", 32'(data_data_ok), 32'd1);
    check("t1_rdata", data_rdata, 32'hDEADBEEF);
    cyc();
    #1 check("t1_ok_pulse", 32'(data_data_ok), 32'd0);

    // Byte store, AW accepted two cycles before W
    req(1'b1, 2'd0, 32'h1C000203, 4'b1000, 32'hAB000000);
    #1 check("t2_addr_ok", 32'(data_addr_ok), 32'd1);
    sb.push_back('{32'hDEADBEEF, 1'b0});
    cyc(); data_req = 1'b0; data_wdata = 32'h0; data_wstrb = 4'h0; awready = 1'b1;
    #1 check("t2_aw_w_valid", 32'({awvalid, wvalid, wlast, bready}), 32'b1110);
    check("t2_awaddr", awaddr, 32'h1C000203);
    check("t2_awsize", 32'(awsize), 32'd0);
    check("t2_wstrb", 32'(wstrb), 32'h8);
    check("t2_wdata", wdata, 32'hAB000000);
    cyc(); awready = 1'b0;
    #1 check("t2_aw_dropped", 32'({awvalid, wvalid, bready}), 32'b010);
    cyc(); wready = 1'b1;
    #1 check("t2_w_held", 32'({awvalid, wvalid, bready}), 32'b010);
    cyc(); wready = 1'b0; bvalid = 1'b1;
    #1 check("t2_bready", 32'({awvalid, wvalid, bready}), 32'b001);
    cyc(); bvalid = 1'b0;
    #1 check("t2_ok", 32'(data_data_ok), 32'd1);
    check("t2_rdata_kept", data_rdata, 32'hDEADBEEF);
    cyc();
    #1 check("t2_ok_pulse", 32'(data_data_ok), 32'd0);

    // data_req held high: next accept coincides with previous data_ok
    req(1'b0, 2'd2, 32'h1C000500, 4'hF, 32'd0);
    #1 check("t3_addr_ok0", 32'(data_addr_ok), 32'd1);
    sb.push_back('{32'h11111111, 1'b0});
    cyc(); data_addr = 32'h1C000504; arready = 1'b1;
    #1 check("t3_busy_no_ok", 32'(data_addr_ok), 32'd0);
    check("t3_araddr_latched", araddr, 32'h1C000500);
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h11111111;
    #1 check("t3_busy_no_ok_r", 32'(data_addr_ok), 32'd0);
    cyc(); rvalid = 1'b0;
    #1 check("t3_ok_and_accept", 32'({data_data_ok, data_addr_ok}), 32'b11);
    sb.push_back('{32'h22222222, 1'b0});
    cyc(); data_req = 1'b0; arready = 1'b1;
    #1 check("t3_araddr2", araddr, 32'h1C000504);
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h22222222;
    cyc(); rvalid = 1'b0;
    #1 check("t3_ok2", 32'(data_data_ok), 32'd1);
    cyc();

    // arready delayed five cycles while data_req toggles
    req(1'b0, 2'd2, 32'h1C000400, 4'hF, 32'd0);
    #1 check("t4_addr_ok", 32'(data_addr_ok), 32'd1);
    sb.push_back('{32'h33333333, 1'b0});
    for (int i = 0; i < 5; i++) begin
      cyc();
      data_req  = (i % 2 == 0);
      data_addr = $urandom;
      #1 check("t4_no_addr_ok", 32'(data_addr_ok), 32'd0);
      check("t4_araddr_stable", araddr, 32'h1C000400);
      check("t4_arvalid_held", 32'(arvalid), 32'd1);
    end
    cyc(); data_req = 1'b0; arready = 1'b1;
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h33333333;
    #1 check("t4_rready", 32'(rready), 32'd1);
    cyc(); rvalid = 1'b0;
    #1 check("t4_ok", 32'(data_data_ok), 32'd1);
    cyc();

    // Reset while waiting for R: no completion may follow
    req(1'b0, 2'd2, 32'h1C000600, 4'hF, 32'd0);
    #1 check("t5_addr_ok", 32'(data_addr_ok), 32'd1);
    cyc(); data_req = 1'b0; arready = 1'b1;
    cyc(); arready = 1'b0;
    #1 check("t5_in_rd_r", 32'(rready), 32'd1);
    resetn = 1'b0; rvalid = 1'b1; rdata = 32'h44444444;
    #1 check("t5_rst_strobes", 32'({arvalid, rready, awvalid, wvalid, bready, data_data_ok}), 32'd0);
    check("t5_rst_rdata", data_rdata, 32'd0);
    cyc();
    #1 check("t5_rst_no_ok", 32'(data_data_ok), 32'd0);
    cyc(); resetn = 1'b1; rvalid = 1'b0; rdata = 32'd0;
    repeat (4) begin
      cyc();
      check("t5_no_ok_after", 32'({data_data_ok, rready}), 32'd0);
    end

    // Same-cycle AW/W with error response, then OKAY load
    req(1'b1, 2'd2, 32'h1C000700, 4'hF, 32'h12345678);
    #1 check("t6_addr_ok", 32'(data_addr_ok), 32'd1);
    sb.push_back('{32'h00000000, 1'b1});
    cyc(); data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    #1 check("t6_both_done", 32'({awvalid, wvalid, bready}), 32'b001);
    cyc(); bvalid = 1'b0; bresp = 2'b00;
    #1 check("t6_ok", 32'(data_data_ok), 32'd1);
    cyc();
    req(1'b0, 2'd2, 32'h1C000704, 4'hF, 32'd0);
    #1 check("t6_addr_ok2", 32'(data_addr_ok), 32'd1);
    sb.push_back('{32'h55555555, 1'b0});
    cyc(); data_req = 1'b0; arready = 1'b1;
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h55555555; rresp = 2'b00;
    cyc(); rvalid = 1'b0;
    #1 check("t6_ok2", 32'(data_data_ok), 32'd1);
    cyc(); cyc();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
